bcd_7seg_scan_driver: RTL and testbench
=======================================

// Module: bcd_7seg_scan_driver
// PURPOSE
//  Downstream consumer of the binary-to-BCD converter. Latches a packed BCD word and
//  drives a multiplexed common-segment 7-segment display, one digit at a time.
//  Time-multiplexes digits with a refresh counter, optionally blanks leading zeros,
//  and flags non-BCD nibbles. Sits between the BCD converter and the board display pins.
// PARAMETERS
//  NUM_DIGITS   2  number of BCD digits / display positions (>=1)
//  REFRESH_DIV  4  clk cycles each digit stays selected (>=1)
//  BLANK_LEAD   1  1 = blank leading-zero digits; 0 = show all digits
// PORTS
//  clk      in   1              rising-edge clock
//  rst      in   1              asynchronous reset, active-high
//  load     in   1              capture bcd_in into the shadow register this edge
//  bcd_in   in   4*NUM_DIGITS   packed BCD; nibble 0 = least-significant digit
//  seg      out  7              segments {g,f,e,d,c,b,a}, active-high
//  an       out  NUM_DIGITS     one-hot digit enable, active-high; bit i = digit i
//  digit_idx out $clog2(NUM_DIGITS) (min 1)  index of the digit currently driven
//  err      out  1              1 while any shadow nibble > 9
// BEHAVIOUR
//  State: shadow[4*NUM_DIGITS-1:0], refresh counter cnt, digit index idx.
//  Reset (async, immediate on rst=1): shadow=0, cnt=0, idx=0 -> an=1 (digit 0),
//   seg=7'h3F, err=0. Held while rst=1. On release, scanning starts at the next edge.
//  Load: on a rising edge with load=1, shadow <= bcd_in. seg/err reflect the new value
//   from that edge on (1-cycle latency from bcd_in to outputs). load=0 holds shadow.
//   load does not disturb cnt/idx.
//  Scan: cnt increments every edge. At cnt==REFRESH_DIV-1, cnt<=0 and
//   idx<=idx+1, wrapping NUM_DIGITS-1 -> 0. Each digit is selected for exactly
//   REFRESH_DIV cycles; full frame = NUM_DIGITS*REFRESH_DIV cycles.
//   NUM_DIGITS=1: idx stays 0, an stays 1. REFRESH_DIV=1: idx advances every edge.
//  Outputs decoded from registered state only (no input-to-output comb path):
//   an = 1 << idx; digit_idx = idx; seg = decode(shadow nibble idx).
//  Decode: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F; 10-15: 40 (dash).
//  Blanking (BLANK_LEAD=1): digit i>0 shows seg=7'h00 when nibble i and every
//   higher nibble are 0. Digit 0 never blanked (value 0 shows "0"). an is still
//   asserted for a blanked digit. Non-BCD nibble is never blanked (it is non-zero).
//  err = OR over nibbles of (nibble > 9); combinational from shadow only.
//  Simultaneous load and digit advance: both take effect on the same edge;
//   new idx is decoded from new shadow.
//  Reset mid-frame: scan restarts at digit 0 with full REFRESH_DIV dwell.
// TESTING (NUM_DIGITS=2, REFRESH_DIV=4, BLANK_LEAD=1 unless stated)
//  1. rst=1 with load=1, bcd_in=8'h99 -> an=2'b01, seg=7'h3F, err=0, digit_idx=0;
//     outputs stay fixed until rst=0.
//  2. load 8'h15 -> digit 0: an=01 seg=6D for 4 cycles; then an=10 seg=06
//     for 4 cycles; then wraps to an=01; period 8 cycles.
//  3. load 8'h07 -> digit 1 slot: an=10 seg=00; digit 0 slot seg=07. Repeat with
//     BLANK_LEAD=0 -> digit 1 slot seg=3F.
//  4. load 8'h0A -> err=1 next cycle; digit 0 seg=40; digit 1 seg=00 (blanked);
//     then load 8'h42 -> err=0, digits show 5B then 66.
//  5. load=0 while bcd_in toggles randomly for 3 frames -> seg pattern unchanged;
//     load pulse coinciding with idx advance -> new digit shows new value same edge.
//  6. assert rst at cnt=2 of digit 1 -> an=01, seg=3F immediately (before next
//     edge); after release digit 0 held exactly 4 cycles.

Source files
------------

// File: rtl/bcd_7seg_scan_driver.sv
// Multiplexed 7-segment scan driver: latches a packed BCD word, scans one digit per
// refresh slot, optionally blanks leading zeros and flags non-BCD nibbles.
module bcd_7seg_scan_driver #(
   parameter int NUM_DIGITS  = 2,
   parameter int REFRESH_DIV = 4,
   parameter bit BLANK_LEAD  = 1'b1,
   localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [IDX_W-1:0]        digit_idx,
   output logic                    err
);

   localparam int               CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [4*NUM_DIGITS-1:0] shadow;
   logic [CNT_W-1:0]        cnt;
   logic [IDX_W-1:0]        idx;
   logic [3:0]              cur_nib;
   logic [NUM_DIGITS:0]     zero_above;
   logic                    blank;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow <= '0;
         cnt    <= '0;
         idx    <= '0;
      end else begin
         if (load)
            shadow <= bcd_in;
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // zero_above[i] is set when nibble i and every higher nibble are zero
   always_comb begin
      zero_above             = '0;
      zero_above[NUM_DIGITS] = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--)
         zero_above[i] = zero_above[i+1] && (shadow[4*i +: 4] == 4'd0);
   end

   always_comb begin
      err = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++)
         err = err | (shadow[4*i +: 4] > 4'd9);
   end

   assign cur_nib   = shadow[4*idx +: 4];
   assign blank     = BLANK_LEAD && (idx != '0) && zero_above[idx];
   assign seg       = blank ? 7'h00 : decode(cur_nib);
   assign an        = NUM_DIGITS'(1) << idx;
   assign digit_idx = idx;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Scoreboard bench for bcd_7seg_scan_driver: a behavioural model pushes the expected
// display state for each edge, and the post-edge sample is popped and compared.
module tb_bcd_7seg_scan_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0;
   logic [7:0] bcd_in = 8'h00;
   logic [6:0] seg, seg_nb;
   logic [1:0] an, an_nb;
   logic       digit_idx, digit_idx_nb;
   logic       err, err_nb;

   bcd_7seg_scan_driver #(.NUM_DIGITS(2), .REFRESH_DIV(4), .BLANK_LEAD(1'b1)) u_dut (
      .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
      .seg(seg), .an(an), .digit_idx(digit_idx), .err(err));

   bcd_7seg_scan_driver #(.NUM_DIGITS(2), .REFRESH_DIV(4), .BLANK_LEAD(1'b0)) u_dut_nb (
      .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
      .seg(seg_nb), .an(an_nb), .digit_idx(digit_idx_nb), .err(err_nb));

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] seg;
      logic [6:0] seg_nb;
      logic [1:0] an;
      logic       di;
      logic       err;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_err    = 0;

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

   logic [7:0] m_shadow;
   int         m_cnt, m_idx;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic exp_t model_out();
      exp_t       e;
      logic [3:0] nib;
      logic [3:0] hi;
      nib = (m_idx == 0) ? m_shadow[3:0] : m_shadow[7:4];
      hi  = m_shadow[7:4];
      e.seg_nb = seg_tab[nib];
      e.seg    = (m_idx == 1 && hi == 4'd0) ? 7'h00 : seg_tab[nib];
      e.an     = (m_idx == 0) ? 2'b01 : 2'b10;
      e.di     = (m_idx == 1);
      e.err    = (m_shadow[3:0] > 4'd9) || (m_shadow[7:4] > 4'd9);
      return e;
   endfunction

   task automatic check_now(input string tag);
      exp_t e;
      e = model_out();
      chk({tag, "_seg"}, seg, e.seg);
      chk({tag, "_an"}, an, e.an);
      chk({tag, "_idx"}, digit_idx, e.di);
      chk({tag, "_err"}, err, e.err);
      chk({tag, "_seg_nb"}, seg_nb, e.seg_nb);
   endtask

   // one clock with the given inputs: model predicts, edge happens, sample is scored
   task automatic cycle(input logic ld, input logic [7:0] val);
      exp_t e;
      load   = ld;
      bcd_in = val;
      if (ld) m_shadow = val;
      if (m_cnt == 3) begin
         m_cnt = 0;
         m_idx = (m_idx + 1) % 2;
      end else begin
         m_cnt++;
      end
      q.push_back(model_out());
      @(posedge clk);
      #1;
      chk("sb_depth", q.size(), 1);
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("seg", seg, e.seg);
         chk("an", an, e.an);
         chk("digit_idx", digit_idx, e.di);
         chk("err", err, e.err);
         chk("seg_nb", seg_nb, e.seg_nb);
      end
   endtask

   task automatic model_reset();
      m_shadow = 8'h00;
      m_cnt    = 0;
      m_idx    = 0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, bcd_in);
   endtask

   task automatic load_at_digit0(input logic [7:0] val);
      while (!(m_idx == 1 && m_cnt == 3)) cycle(1'b0, bcd_in);
      cycle(1'b1, val);
   endtask

   initial begin
      int dwell;
      model_reset();

      // reset dominates load; outputs frozen while rst is high
      rst    = 1'b1;
      load   = 1'b1;
      bcd_in = 8'h99;
      #1;
      chk("rst_seg", seg, 7'h3F);
      chk("rst_an", an, 2'b01);
      chk("rst_idx", digit_idx, 1'b0);
      chk("rst_err", err, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rst_hold_seg", seg, 7'h3F);
         chk("rst_hold_an", an, 2'b01);
      end
      load = 1'b0;
      rst  = 1'b0;

      // 15: 5 on digit 0, 1 on digit 1, 4-cycle dwell each
      cycle(1'b1, 8'h15);
      run(2);
      chk("t2_d0_seg", seg, 7'h6D);
      run(1);
      chk("t2_d1_seg", seg, 7'h06);
      chk("t2_d1_an", an, 2'b10);
      run(12);

      // 07: leading zero blanked, non-blanking instance shows "0"
      load_at_digit0(8'h07);
      run(4);
      chk("t3_blank_seg", seg, 7'h00);
      chk("t3_blank_an", an, 2'b10);
      chk("t3_noblank_seg", seg_nb, 7'h3F);
      run(4);

      // 0A: non-BCD low nibble, dash, err; then 42 clears err
      load_at_digit0(8'h0A);
      chk("t4_err", err, 1'b1);
      chk("t4_dash", seg, 7'h40);
      run(4);
      chk("t4_d1_blank", seg, 7'h00);
      load_at_digit0(8'h42);
      chk("t4_err_clr", err, 1'b0);
      chk("t4_d0", seg, 7'h5B);
      run(4);
      chk("t4_d1", seg, 7'h66);

      // load held low while bcd_in churns for three frames
      for (int i = 0; i < 24; i++) cycle(1'b0, 8'($urandom));

      // load coinciding with the digit advance
      while (!(m_idx == 0 && m_cnt == 3)) cycle(1'b0, bcd_in);
      cycle(1'b1, 8'h38);
      chk("t5_coinc_an", an, 2'b10);
      chk("t5_coinc_seg", seg, 7'h4F);
      cycle(1'b1, 8'h9F);
      chk("t5_err_both", err, 1'b1);
      run(8);

      // async reset at cnt==2 of digit 1
      cycle(1'b1, 8'h56);
      while (!(m_idx == 1 && m_cnt == 2)) cycle(1'b0, bcd_in);
      chk("t6_pre_an", an, 2'b10);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("t6_async_an", an, 2'b01);
      chk("t6_async_seg", seg, 7'h3F);
      check_now("t6_async");
      @(posedge clk);
      #1;
      rst = 1'b0;
      dwell = 1;
      for (int i = 0; i < 8 && an == 2'b01; i++) begin
         cycle(1'b0, bcd_in);
         if (an == 2'b01) dwell++;
      end
      chk("t6_dwell", dwell, 4);
      run(4);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1, "timeout");
   end

endmodule
